// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO register offsets
// and the address-decode result type.
package dmem_pkg;

  localparam logic [7:0] OFF_CYCLES  = 8'h00;
  localparam logic [7:0] OFF_LOADS   = 8'h08;
  localparam logic [7:0] OFF_STORES  = 8'h10;
  localparam logic [7:0] OFF_ERRADDR = 8'h18;
  localparam logic [7:0] OFF_STATUS  = 8'h20;
  localparam logic [7:0] OFF_DONE    = 8'h28;

  typedef enum logic [1:0] {
    DEC_RAM,
    DEC_MMIO,
    DEC_MISALIGN,
    DEC_UNMAPPED
  } dec_e;

endpackage

// File: rtl/dmem_mmio_regs.sv
// Memory-mapped register bank: cycle/load/store counters, sticky error
// capture, DONE register and the read mux for the MMIO window.
module dmem_mmio_regs
  import dmem_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_sel,
  input  logic         i_validRd,
  input  logic         i_validWr,
  input  logic         i_err,
  input  logic [7:0]   i_off,
  input  logic [N-1:0] i_addr,
  input  logic [N-1:0] i_wdata,
  output logic [N-1:0] o_rdata,
  output logic         o_err,
  output logic         o_done,
  output logic [N-1:0] o_doneCode
);

  logic [N-1:0] r_cycles;
  logic [N-1:0] r_loads;
  logic [N-1:0] r_stores;
  logic [N-1:0] r_errAddr;
  logic         r_err;
  logic         r_done;
  logic [N-1:0] r_doneCode;

  logic w_statusClr;
  logic w_doneWr;

  assign w_statusClr = i_validWr && i_sel && (i_off == OFF_STATUS) && i_wdata[0];
  assign w_doneWr    = i_validWr && i_sel && (i_off == OFF_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycles   <= '0;
      r_loads    <= '0;
      r_stores   <= '0;
      r_errAddr  <= '0;
      r_err      <= 1'b0;
      r_done     <= 1'b0;
      r_doneCode <= '0;
    end else begin
      r_cycles <= r_cycles + 1'b1;
      if (i_validRd) r_loads  <= r_loads + 1'b1;
      if (i_validWr) r_stores <= r_stores + 1'b1;
      // A fresh error outranks a simultaneous clear through STATUS.
      if (i_err) begin
        r_err <= 1'b1;
        if (!r_err) r_errAddr <= i_addr;
      end else if (w_statusClr) begin
        r_err <= 1'b0;
      end
      if (w_doneWr) begin
        r_done     <= 1'b1;
        r_doneCode <= i_wdata;
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    if (i_sel) begin
      case (i_off)
        OFF_CYCLES:  o_rdata = r_cycles;
        OFF_LOADS:   o_rdata = r_loads;
        OFF_STORES:  o_rdata = r_stores;
        OFF_ERRADDR: o_rdata = r_errAddr;
        OFF_STATUS:  o_rdata = {{(N-1){1'b0}}, r_err};
        OFF_DONE:    o_rdata = r_doneCode;
        default:     o_rdata = '0;
      endcase
    end
  end

  assign o_err      = r_err;
  assign o_done     = r_done;
  assign o_doneCode = r_doneCode;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: address decode, word-addressed RAM with zero-latency
// reads, and the final read mux over RAM and the MMIO register bank.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int             N         = 64,
  parameter int             DEPTH     = 64,
  parameter logic [N-1:0]   MMIO_BASE = 64'h1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] DM_addr,
  input  logic [N-1:0] DM_writeData,
  input  logic         DM_writeEnable,
  input  logic         DM_readEnable,
  output logic [N-1:0] DM_readData,
  output logic         err,
  output logic         done,
  output logic [N-1:0] done_code
);

  localparam int           AW        = $clog2(DEPTH);
  localparam logic [N-1:0] RAM_BYTES = N'(DEPTH * 8);
  localparam logic [N-1:0] MMIO_LAST = MMIO_BASE + N'(OFF_DONE);

  logic [N-1:0] r_mem [DEPTH];

  dec_e         w_dec;
  logic [AW-1:0] w_idx;
  logic [7:0]   w_off;
  logic         w_anyEn;
  logic         w_mapped;
  logic         w_err;
  logic         w_validRd;
  logic         w_validWr;
  logic [N-1:0] w_mmioRdata;

  always_comb begin
    w_dec = DEC_UNMAPPED;
    if (DM_addr[2:0] != 3'b000)                          w_dec = DEC_MISALIGN;
    else if (DM_addr < RAM_BYTES)                        w_dec = DEC_RAM;
    else if (DM_addr >= MMIO_BASE && DM_addr <= MMIO_LAST) w_dec = DEC_MMIO;
  end

  assign w_idx     = DM_addr[AW+2:3];
  assign w_off     = 8'(DM_addr - MMIO_BASE);
  assign w_anyEn   = DM_writeEnable || DM_readEnable;
  assign w_mapped  = (w_dec == DEC_RAM) || (w_dec == DEC_MMIO);
  assign w_err     = w_anyEn && !w_mapped;
  assign w_validRd = DM_readEnable && w_mapped;
  assign w_validWr = DM_writeEnable && w_mapped;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_validWr && w_dec == DEC_RAM) begin
      r_mem[w_idx] <= DM_writeData;
    end
  end

  dmem_mmio_regs #(.N(N)) u_regs (
    .clk        (clk),
    .reset      (reset),
    .i_sel      (w_dec == DEC_MMIO),
    .i_validRd  (w_validRd),
    .i_validWr  (w_validWr),
    .i_err      (w_err),
    .i_off      (w_off),
    .i_addr     (DM_addr),
    .i_wdata    (DM_writeData),
    .o_rdata    (w_mmioRdata),
    .o_err      (err),
    .o_done     (done),
    .o_doneCode (done_code)
  );

  always_comb begin
    DM_readData = '0;
    if (DM_readEnable) begin
      case (w_dec)
        DEC_RAM:  DM_readData = r_mem[w_idx];
        DEC_MMIO: DM_readData = w_mmioRdata;
        default:  DM_readData = '0;
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined 64-bit datapath. It sits on the far end of the DM_addr / DM_writeData / DM_writeEnable / DM_readEnable / DM_readData interface.
- Serves a word-addressed RAM, plus a small memory-mapped register bank: cycle, load and store counters, a sticky error capture, and a DONE register.
- Reads are same-cycle, so the MEM/WB pipeline register captures data at the next edge. Writes and all register updates occur at the clock edge.

Parameters:
- N, 64, data and address width.
- DEPTH, 64, number of N-bit RAM words; must be a power of 2.
- MMIO_BASE, 64'h1000, byte address of the register bank; must be at or above DEPTH*8.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- DM_addr  in  N  byte address
- DM_writeData  in  N  store data
- DM_writeEnable  in  1  store request this cycle
- DM_readEnable  in  1  load request this cycle
- DM_readData  out  N  load data, combinational from DM_addr
- err  out  1  sticky access-error flag
- done  out  1  set by a store to DONE
- done_code  out  N  last value stored to DONE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset effects: clears every RAM word, all counters, err, ERR_ADDR, done and done_code to 0. DM_readData follows the cleared state the same cycle. A reset asserted mid-access aborts the access; the store is not committed.
- Address decode, in order:
  - Misaligned: DM_addr[2:0] != 0.
  - RAM: DM_addr < DEPTH*8; word index DM_addr[log2(DEPTH)+2:3].
  - MMIO: MMIO_BASE <= DM_addr <= MMIO_BASE+0x28.
  - Otherwise: unmapped.
- Valid access: readEnable or writeEnable high, and the address is RAM or MMIO (not misaligned, not unmapped).
- Read path (DM_readEnable=1):
  - DM_readData is the addressed RAM word or register value, with zero latency.
  - It returns the pre-edge state: CYCLES shows the value before this cycle's increment.
  - With readEnable=0, DM_readData=0.
  - Misaligned or unmapped reads return 0.
- Write path (DM_writeEnable=1): the RAM word or writable register updates at the clock edge.
- Both enables high: the read returns the old value and the write commits at the edge. This is not an error.
- MMIO map (offset from MMIO_BASE):
  - 0x00 CYCLES (RO): increments every non-reset cycle, wraps at 2^N.
  - 0x08 LOADS (RO): +1 per valid read.
  - 0x10 STORES (RO): +1 per valid write. A both-enables access increments both LOADS and STORES.
  - 0x18 ERR_ADDR (RO): DM_addr of the first error since err was last cleared.
  - 0x20 STATUS: bit0 = err. Writing with bit0=1 clears err and re-arms ERR_ADDR capture. If a new error occurs in the same cycle, the error wins: err stays 1 and ERR_ADDR takes the new address.
  - 0x28 DONE: any store sets done=1 and done_code=DM_writeData. Later stores update done_code only. done stays 1 until reset. Reads return done_code.
- Writes to RO registers are ignored but still count as valid stores.
- Error condition: an enable is high and the address is misaligned or unmapped. Effects:
  - err set at the edge.
  - ERR_ADDR captured only if err was 0.
  - Any store is suppressed.
  - LOADS and STORES are not incremented.
- No enable high: no state change except CYCLES.

Decomposition:
- Package dmem_pkg holds:
  - MMIO offset localparams: OFF_CYCLES, OFF_LOADS, OFF_STORES, OFF_ERRADDR, OFF_STATUS, OFF_DONE.
  - An enum for decode result: DEC_RAM, DEC_MMIO, DEC_MISALIGN, DEC_UNMAPPED.
- Sub-module dmem_mmio_regs holds the counters, error capture and DONE logic, plus the read mux for the MMIO region.
- The top level holds address decode, the RAM array and the final read mux.

Test Plan:
- Reset, then store 64'hDEADBEEF_0BADF00D at 0x10 and load 0x10 the next cycle -> DM_readData = 64'hDEADBEEF_0BADF00D; STORES=1, LOADS=1.
- Load 0x10 and store 64'h5 to 0x10 in the same cycle -> that cycle's DM_readData = old value; the next cycle's load returns 64'h5.
- Store to 0x0C (misaligned) -> err=1, ERR_ADDR=0x0C, RAM unchanged. Then load 0x2000 (unmapped) -> returns 0, ERR_ADDR stays 0x0C. Then store 1 to MMIO_BASE+0x20 -> err=0. Then load 0x2000 again -> ERR_ADDR=0x2000.
- After 10 cycles out of reset, load MMIO_BASE+0x00 -> DM_readData = 10. Store to MMIO_BASE+0x00 -> CYCLES still counts, STORES increments.
- Store 64'h2A to MMIO_BASE+0x28 -> done=1, done_code=0x2A. Store 0x7 -> done_code=0x7, done stays 1. Assert reset -> done=0, done_code=0, RAM word 0x10 reads 0.
